// File: rtl/tc_sram_pm_pkg.sv
// Shared types and helpers for the power-managed SRAM wrapper.
package tc_sram_pm_pkg;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SLEEP  = 2'd2,
        ST_WAKE   = 2'd3
    } pm_state_e;

    // A zero-length wake would skip the WAKE state entirely, so clamp to one cycle.
    function automatic int unsigned wake_len(input int unsigned cycles);
        return (cycles == 0) ? 1 : cycles;
    endfunction

endpackage

// File: rtl/tc_sram.sv
// Multi-port byte-enabled SRAM with registered read and a Latency-deep read data pipeline.
module tc_sram #(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned DataWidth = 128,
    parameter int unsigned ByteWidth = 8,
    parameter int unsigned NumPorts  = 2,
    parameter int unsigned Latency   = 1,
    parameter string       SimInit   = "none",
    parameter string       ImplKey   = "none"
) (
    input  logic                                            clk_i,
    input  logic                                            rst_ni,
    input  logic [NumPorts-1:0]                             req_i,
    input  logic [NumPorts-1:0]                             we_i,
    input  logic [NumPorts-1:0][$clog2(NumWords)-1:0]       addr_i,
    input  logic [NumPorts-1:0][DataWidth-1:0]              wdata_i,
    input  logic [NumPorts-1:0][DataWidth/ByteWidth-1:0]    be_i,
    output logic [NumPorts-1:0][DataWidth-1:0]              rdata_o
);

    localparam int unsigned BeW = DataWidth / ByteWidth;
    // Output registers are only cleared on reset when explicitly requested; the array never is.
    localparam bit ClearOut = (SimInit == "zeros") || (ImplKey == "clear_out");

    logic [DataWidth-1:0] mem_q [NumWords];

    // Later ports overwrite earlier ones, so the highest-index writer wins on a collision.
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < NumPorts; p++) begin
            if (req_i[p] && we_i[p]) begin
                for (int b = 0; b < BeW; b++) begin
                    if (be_i[p][b]) begin
                        mem_q[addr_i[p]][b*ByteWidth +: ByteWidth] <= wdata_i[p][b*ByteWidth +: ByteWidth];
                    end
                end
            end
        end
    end

    for (genvar gi = 0; gi < NumPorts; gi++) begin : g_rd
        logic [Latency-1:0][DataWidth-1:0] pipe_q;

        always_ff @(posedge clk_i) begin
            if (ClearOut && !rst_ni) begin
                pipe_q <= '0;
            end else begin
                if (req_i[gi] && !we_i[gi]) begin
                    pipe_q[0] <= mem_q[addr_i[gi]];
                end
                for (int s = 1; s < Latency; s++) begin
                    pipe_q[s] <= pipe_q[s-1];
                end
            end
        end

        assign rdata_o[gi] = pipe_q[Latency-1];
    end

endmodule

// File: rtl/tc_sram_pm.sv
// SRAM wrapper with a sleep/retention FSM: drains in-flight reads, sleeps, and wakes on demand.
module tc_sram_pm
    import tc_sram_pm_pkg::*;
#(
    parameter int unsigned NumWords        = 1024,
    parameter int unsigned DataWidth       = 128,
    parameter int unsigned ByteWidth       = 8,
    parameter int unsigned NumPorts        = 2,
    parameter int unsigned Latency         = 1,
    parameter string       SimInit         = "none",
    parameter int unsigned WakeCycles      = 4,
    parameter int unsigned IdleSleepCycles = 0,
    parameter string       ImplKey         = "none"
) (
    input  logic                                            clk_i,
    input  logic                                            rst_i,
    input  logic                                            sleep_req_i,
    output logic                                            sleep_o,
    input  logic [NumPorts-1:0]                             req_i,
    output logic [NumPorts-1:0]                             gnt_o,
    input  logic [NumPorts-1:0]                             we_i,
    input  logic [NumPorts-1:0][$clog2(NumWords)-1:0]       addr_i,
    input  logic [NumPorts-1:0][DataWidth-1:0]              wdata_i,
    input  logic [NumPorts-1:0][DataWidth/ByteWidth-1:0]    be_i,
    output logic [NumPorts-1:0][DataWidth-1:0]              rdata_o,
    output logic [NumPorts-1:0]                             rvalid_o
);

    localparam int unsigned WakeLen = wake_len(WakeCycles);
    localparam int unsigned WakeW   = $clog2(WakeLen + 1);
    localparam int unsigned IdleW   = $clog2(IdleSleepCycles + 2);

    pm_state_e            state_q;
    logic [IdleW-1:0]     idle_q;
    logic [WakeW-1:0]     wake_q;
    logic                 by_req_q;
    logic                 wake_sleep_q;
    logic                 sleep_q;

    logic                 any_req;
    logic                 auto_fire;
    logic [NumPorts-1:0]  gnt;
    logic [NumPorts-1:0]  rd_issue;
    logic [NumPorts-1:0]  pend_p;

    assign any_req   = |req_i;
    assign auto_fire = (IdleSleepCycles != 0) && (idle_q == IdleW'(IdleSleepCycles));
    assign gnt       = (state_q == ST_ACTIVE && !sleep_req_i && !auto_fire && !rst_i) ? req_i : '0;
    assign rd_issue  = gnt & ~we_i;
    assign gnt_o     = gnt;
    assign sleep_o   = sleep_q;

    // pend_p flags reads that will still be in flight after the current edge.
    for (genvar gi = 0; gi < NumPorts; gi++) begin : g_vld
        logic [Latency-1:0] vld_q;

        if (Latency == 1) begin : g_l1
            always_ff @(posedge clk_i) begin
                if (rst_i) vld_q <= '0;
                else       vld_q <= rd_issue[gi];
            end
            assign pend_p[gi] = 1'b0;
        end else begin : g_ln
            always_ff @(posedge clk_i) begin
                if (rst_i) vld_q <= '0;
                else       vld_q <= {vld_q[Latency-2:0], rd_issue[gi]};
            end
            assign pend_p[gi] = |vld_q[Latency-2:0];
        end

        assign rvalid_o[gi] = vld_q[Latency-1] & ~rst_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_ACTIVE;
            idle_q       <= '0;
            wake_q       <= '0;
            by_req_q     <= 1'b0;
            wake_sleep_q <= 1'b0;
            sleep_q      <= 1'b0;
        end else begin
            unique case (state_q)
                ST_ACTIVE: begin
                    if (sleep_req_i || auto_fire) begin
                        state_q  <= ST_DRAIN;
                        by_req_q <= sleep_req_i;
                        idle_q   <= '0;
                    end else if (any_req) begin
                        idle_q <= '0;
                    end else if (idle_q != IdleW'(IdleSleepCycles)) begin
                        idle_q <= idle_q + IdleW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (sleep_req_i) by_req_q <= 1'b1;
                    if (!(|pend_p)) begin
                        state_q <= ST_SLEEP;
                        sleep_q <= 1'b1;
                    end
                end
                ST_SLEEP: begin
                    // An auto-entered sleep has no sleep request to release, so only traffic wakes it.
                    if (sleep_req_i) begin
                        by_req_q <= 1'b1;
                    end else if (any_req || by_req_q) begin
                        state_q      <= ST_WAKE;
                        sleep_q      <= 1'b0;
                        wake_q       <= '0;
                        wake_sleep_q <= 1'b0;
                    end
                end
                ST_WAKE: begin
                    if (wake_q == WakeW'(WakeLen - 1)) begin
                        wake_q <= '0;
                        if (wake_sleep_q || sleep_req_i) begin
                            state_q  <= ST_DRAIN;
                            by_req_q <= 1'b1;
                        end else begin
                            state_q <= ST_ACTIVE;
                        end
                    end else begin
                        wake_q <= wake_q + WakeW'(1);
                        if (sleep_req_i) wake_sleep_q <= 1'b1;
                    end
                end
                default: state_q <= ST_ACTIVE;
            endcase
        end
    end

    tc_sram #(
        .NumWords  (NumWords),
        .DataWidth (DataWidth),
        .ByteWidth (ByteWidth),
        .NumPorts  (NumPorts),
        .Latency   (Latency),
        .SimInit   (SimInit),
        .ImplKey   (ImplKey)
    ) u_sram (
        .clk_i   (clk_i),
        .rst_ni  (~rst_i),
        .req_i   (gnt),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .be_i    (be_i),
        .rdata_o (rdata_o)
    );

endmodule

// File: tb/tb_tc_sram_pm.sv
// Directed and randomized checks of tc_sram_pm against a cycle-level behavioural model.
module tb_tc_sram_pm;

    localparam int NW = 16, DW = 32, BW = 8, NP = 2, LAT = 2, WAKE = 4, IDLE = 3;
    localparam int AW = 4, BEW = DW / BW;

    logic clk = 1'b0;
    logic rst, sleep_req, sleep_o;
    logic [NP-1:0] req, gnt, we, rvalid;
    logic [NP-1:0][AW-1:0] addr;
    logic [NP-1:0][DW-1:0] wdata, rdata;
    logic [NP-1:0][BEW-1:0] be;

    always #5 clk = ~clk;

    tc_sram_pm #(
        .NumWords(NW), .DataWidth(DW), .ByteWidth(BW), .NumPorts(NP), .Latency(LAT),
        .SimInit("none"), .WakeCycles(WAKE), .IdleSleepCycles(IDLE), .ImplKey("none")
    ) dut (
        .clk_i(clk), .rst_i(rst), .sleep_req_i(sleep_req), .sleep_o(sleep_o),
        .req_i(req), .gnt_o(gnt), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .be_i(be), .rdata_o(rdata), .rvalid_o(rvalid)
    );

    int checks = 0, errors = 0;

    typedef enum int {M_ACT, M_DRAIN, M_SLEEP, M_WAKE} mode_t;
    typedef struct { int due; int port; logic [DW-1:0] data; } rd_t;

    logic [DW-1:0] mem_m [NW];
    rd_t   inflight[$];
    mode_t mode = M_ACT;
    int    idle_run = 0, wake_left = 0, cyc_n = 0;
    bit    sleep_by_req = 0, wake_sleep = 0;

    logic [NP-1:0] last_gnt, last_rvalid;
    logic [NP-1:0][DW-1:0] last_rdata;
    logic last_sleep;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic [1:0] r, input logic [1:0] w, input int a0, input int a1,
                         input logic [31:0] d0, input logic [31:0] d1);
        req = r; we = w;
        addr[0] = AW'(a0); addr[1] = AW'(a1);
        wdata[0] = d0; wdata[1] = d1;
        be[0] = '1; be[1] = '1;
    endtask

    // One clock cycle: compare DUT outputs with the model, then advance the model.
    task automatic tick();
        logic [NP-1:0] eg, ev;
        logic [NP-1:0][DW-1:0] ed;
        bit fire, later, exp_sleep;
        rd_t keep[$];
        rd_t e;
        #3;
        eg = '0; ev = '0; ed = '0; fire = 0; later = 0;
        exp_sleep = (mode == M_SLEEP);
        foreach (inflight[k]) begin
            if (inflight[k].due == cyc_n) begin
                ev[inflight[k].port] = 1'b1;
                ed[inflight[k].port] = inflight[k].data;
            end
            if (inflight[k].due > cyc_n) later = 1;
        end
        if (rst) ev = '0;
        if (!rst && mode == M_ACT) begin
            fire = (idle_run >= IDLE);
            if (!sleep_req && !fire) eg = req;
        end
        last_gnt = gnt; last_rvalid = rvalid; last_rdata = rdata; last_sleep = sleep_o;

        checks++;
        assert (gnt === eg) else begin
            errors++; $error("FAIL gnt cyc=%0d obs=%b exp=%b", cyc_n, gnt, eg);
        end
        checks++;
        assert (rvalid === ev) else begin
            errors++; $error("FAIL rvalid cyc=%0d obs=%b exp=%b", cyc_n, rvalid, ev);
        end
        checks++;
        assert (sleep_o === exp_sleep) else begin
            errors++; $error("FAIL sleep cyc=%0d obs=%b exp=%b", cyc_n, sleep_o, exp_sleep);
        end
        for (int p = 0; p < NP; p++) begin
            if (ev[p]) begin
                checks++;
                assert (rdata[p] === ed[p]) else begin
                    errors++; $error("FAIL rdata%0d cyc=%0d obs=%h exp=%h", p, cyc_n, rdata[p], ed[p]);
                end
            end
        end

        if (rst) begin
            mode = M_ACT; idle_run = 0; wake_left = 0; wake_sleep = 0; sleep_by_req = 0;
            inflight.delete();
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (eg[p] && !we[p]) begin
                    e.due = cyc_n + LAT; e.port = p; e.data = mem_m[addr[p]];
                    inflight.push_back(e);
                end
            end
            for (int p = 0; p < NP; p++) begin
                if (eg[p] && we[p]) begin
                    for (int b = 0; b < BEW; b++) begin
                        if (be[p][b]) mem_m[addr[p]][b*BW +: BW] = wdata[p][b*BW +: BW];
                    end
                end
            end
            case (mode)
                M_ACT: begin
                    if (sleep_req || fire) begin
                        mode = M_DRAIN; sleep_by_req = sleep_req; idle_run = 0;
                    end else begin
                        idle_run = (req != 0) ? 0 : ((idle_run < IDLE) ? idle_run + 1 : IDLE);
                    end
                end
                M_DRAIN: begin
                    if (sleep_req) sleep_by_req = 1;
                    if (!later) mode = M_SLEEP;
                end
                M_SLEEP: begin
                    if (sleep_req) sleep_by_req = 1;
                    else if (req != 0 || sleep_by_req) begin
                        mode = M_WAKE; wake_left = (WAKE > 0) ? WAKE : 1; wake_sleep = 0;
                    end
                end
                default: begin
                    if (sleep_req) wake_sleep = 1;
                    wake_left--;
                    if (wake_left == 0) begin
                        if (wake_sleep) begin mode = M_DRAIN; sleep_by_req = 1; end
                        else mode = M_ACT;
                    end
                end
            endcase
            foreach (inflight[k]) if (inflight[k].due > cyc_n) keep.push_back(inflight[k]);
            inflight = keep;
        end
        cyc_n++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wait_n;
        rst = 1'b1; sleep_req = 1'b0;
        drive(2'b00, 2'b00, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        tick();
        chk("rst_gnt", 32'(last_gnt), 0);
        chk("rst_sleep", 32'(last_sleep), 0);
        tick();
        rst = 1'b0;

        // Fill the whole array so every later read has a known value.
        for (int i = 0; i < NW / 2; i++) begin
            drive(2'b11, 2'b11, 2*i, 2*i + 1, $urandom, $urandom);
            tick();
        end

        // Latency-2 write then read of 0xA5.
        drive(2'b01, 2'b01, 3, 0, 32'hA5, 0); tick();
        drive(2'b01, 2'b00, 3, 0, 0, 0); tick();
        chk("rd_gnt", 32'(last_gnt), 1);
        drive(2'b00, 2'b00, 0, 0, 0, 0); tick();
        chk("rd_early", 32'(last_rvalid), 0);
        tick();
        chk("rd_valid", 32'(last_rvalid), 1);
        chk("rd_data", last_rdata[0], 32'hA5);

        // Sleep request while a read is in flight.
        drive(2'b01, 2'b00, 3, 0, 0, 0); tick();
        sleep_req = 1'b1; drive(2'b10, 2'b00, 0, 5, 0, 0); tick();
        chk("drain_gnt", 32'(last_gnt), 0);
        tick();
        chk("drain_rvalid", 32'(last_rvalid), 1);
        chk("drain_sleep", 32'(last_sleep), 0);
        tick();
        chk("sleep_on", 32'(last_sleep), 1);
        chk("sleep_gnt", 32'(last_gnt), 0);
        tick();

        // Release sleep with a request held; grant after the wake window.
        sleep_req = 1'b0; drive(2'b01, 2'b00, 3, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("wake_nogrant", 32'(last_gnt), 0);
        end
        tick();
        chk("wake_grant", 32'(last_gnt), 1);
        drive(2'b00, 2'b00, 0, 0, 0, 0); tick(); tick();
        chk("retain_data", last_rdata[0], 32'hA5);

        // Same-address write collision.
        drive(2'b11, 2'b11, 7, 7, 32'h11, 32'h22); tick();
        drive(2'b01, 2'b00, 7, 0, 0, 0); tick();
        drive(2'b00, 2'b00, 0, 0, 0, 0); tick(); tick();
        chk("collide", last_rdata[0], 32'h22);

        // Auto-sleep after idle, wake only on a request.
        for (int i = 0; i < 8; i++) tick();
        chk("auto_sleep", 32'(last_sleep), 1);
        for (int i = 0; i < 4; i++) tick();
        chk("auto_hold", 32'(last_sleep), 1);
        drive(2'b01, 2'b00, 7, 0, 0, 0);
        wait_n = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (last_gnt[0] === 1'b1) begin wait_n = i; break; end
        end
        chk("auto_wake_lat", wait_n, 5);
        drive(2'b00, 2'b00, 0, 0, 0, 0); tick(); tick();

        // Reset pulse during WAKE.
        sleep_req = 1'b1; tick(); tick(); tick();
        sleep_req = 1'b0; drive(2'b01, 2'b00, 3, 0, 0, 0); tick(); tick();
        rst = 1'b1; tick();
        rst = 1'b0; tick();
        chk("rst_wake_gnt", 32'(last_gnt), 1);
        drive(2'b00, 2'b00, 0, 0, 0, 0); tick(); tick();

        // Reset pulse during DRAIN with a read in flight.
        drive(2'b01, 2'b00, 3, 0, 0, 0); tick();
        sleep_req = 1'b1; drive(2'b00, 2'b00, 0, 0, 0, 0); tick();
        rst = 1'b1; sleep_req = 1'b0; tick();
        chk("rst_drain_rvalid", 32'(last_rvalid), 0);
        rst = 1'b0; drive(2'b01, 2'b00, 7, 0, 0, 0); tick();
        chk("rst_drain_gnt", 32'(last_gnt), 1);
        drive(2'b00, 2'b00, 0, 0, 0, 0); tick(); tick();
        chk("rst_mem_kept", last_rdata[0], 32'h22);

        // Randomized traffic with sleep episodes, idle bursts and occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) sleep_req = ~sleep_req;
            rst = ($urandom_range(0, 99) == 0);
            req = ($urandom_range(0, 9) < 4) ? 2'b00 : 2'($urandom_range(1, 3));
            we = 2'($urandom_range(0, 3));
            addr[0] = AW'($urandom_range(0, NW - 1)); addr[1] = AW'($urandom_range(0, NW - 1));
            wdata[0] = $urandom; wdata[1] = $urandom;
            be[0] = BEW'($urandom); be[1] = BEW'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
